// File: rtl/seq_alu_pkg.sv
// Shared types and op-decode helpers for the sequential ALU and its divider.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIV  = 4'b1100,
    OP_DIVU = 4'b1101,
    OP_REM  = 4'b1110,
    OP_REMU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  function automatic logic is_div(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || is_div(op);
  endfunction

  // Within the divide class: bit 0 clear means signed, bit 1 set means remainder.
  function automatic logic div_signed(input logic [3:0] op);
    return ~op[0];
  endfunction

  function automatic logic div_rem(input logic [3:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// Iterative restoring divider: WIDTH shift/subtract cycles on magnitudes, then one sign-fixup cycle.
module seq_alu_divider
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             want_rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    D_IDLE,
    D_RUN,
    D_FIX
  } dstate_e;

  dstate_e          dstate;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             sel_rem;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted partial remainder.
  always_comb begin
    r_sh = {rem, quo[WIDTH-1]};
    diff = r_sh - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = r_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dstate  <= D_IDLE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
    end else begin
      case (dstate)
        D_IDLE: begin
          if (start) begin
            quo     <= a_mag;
            rem     <= '0;
            dvs     <= b_mag;
            neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r   <= is_signed & a[WIDTH-1];
            sel_rem <= want_rem;
            cnt     <= '0;
            dstate  <= D_RUN;
          end
        end
        D_RUN: begin
          quo <= quo_next;
          rem <= rem_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt    <= '0;
            dstate <= D_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        D_FIX: dstate <= D_IDLE;
        default: dstate <= D_IDLE;
      endcase
    end
  end

  assign done   = (dstate == D_FIX);
  assign result = sel_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add MUL, restoring DIV/REM with valid/ready.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] prod_next;

  alu_op_e          op;
  logic             op_div;
  logic             div_by_zero;
  logic             div_ovf;
  logic             div_special;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_result;
  logic [WIDTH-1:0] quick;

  assign op          = alu_op_e'(alu_control);
  assign op_div      = is_div(alu_control);
  assign div_by_zero = (b == '0);
  assign div_ovf     = div_signed(alu_control) && (a == MIN_VAL) && (b == '1);
  assign div_special = op_div && (div_by_zero || div_ovf);
  assign div_start   = (state == IDLE) && in_valid && op_div && !div_special;

  // Result for everything that completes at the accept edge, including divide special cases.
  always_comb begin
    quick = '0;
    case (op)
      OP_AND:           quick = a & b;
      OP_OR:            quick = a | b;
      OP_ADD:           quick = a + b;
      OP_SUB:           quick = a - b;
      OP_XOR:           quick = a ^ b;
      OP_SLT:           quick = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_DIV, OP_DIVU:  quick = div_by_zero ? '1 : MIN_VAL;
      OP_REM, OP_REMU:  quick = div_by_zero ? a : '0;
      default:          quick = '0;
    endcase
  end

  assign prod_next = mplier[0] ? (prod + mcand) : prod;

  seq_alu_divider #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .is_signed(div_signed(alu_control)),
    .want_rem (div_rem(alu_control)),
    .a        (a),
    .b        (b),
    .done     (div_done),
    .result   (div_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              mcand    <= a;
              mplier   <= b;
              prod     <= '0;
              cnt      <= '0;
              state    <= MUL;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else if (op_div && !div_special) begin
              state    <= DIV;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              result    <= quick;
              zero      <= (quick == '0);
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          prod   <= prod_next;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt       <= '0;
            result    <= prod_next;
            zero      <= (prod_next == '0);
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (div_done) begin
            result    <= div_result;
            zero      <= (div_result == '0);
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results/latencies queued at issue, compared on out_valid.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_control(alu_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx, sy;
    logic ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0011: return x ^ y;
      4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
      4'b1000: return x * y;
      4'b1100: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : W'(sx / sy);
      4'b1101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'b1110: return (y == 0) ? x : ovf ? 32'd0 : W'(sx % sy);
      4'b1111: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    if (op == 4'b1000) return W + 1;
    if (op[3:2] == 2'b11) begin
      if (y == 0) return 1;
      if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return W + 2;
    end
    return 1;
  endfunction

  // Drive one op until accepted; optionally queue its expectation. Inputs are scrambled after accept.
  task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; a = x; b = y;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++; failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_control = 4'($urandom);
    if (push) begin
      e.res = model(op, x, y);
      e.lat = lat_of(op, x, y);
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for out_valid; latency counts the accept edge as cycle 1.
  task automatic recv(output logic [W-1:0] r, output logic z, output int lat, output int busy_n, output bit ok);
    lat = 1; busy_n = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    r = result;
    z = zero;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_control = '0;
    #2;
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== '0)      begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (zero !== 1'b1)      begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_table(input string name, input logic [3:0] ops[], input logic [W-1:0] xs[], input logic [W-1:0] ys[]);
    logic [W-1:0] r; logic z; int lat, bn; bit ok; exp_t e;
    foreach (ops[i]) begin
      send(ops[i], xs[i], ys[i], 1'b1);
      recv(r, z, lat, bn, ok);
      take();
      checks++;
      if (!ok || sb.size() == 0) begin
        failures++; $display("FAIL %s[%0d] no_result out_valid=%b queued=%0d", name, i, ok, sb.size());
        continue;
      end
      e = sb.pop_front();
      checks++; if (r !== e.res) begin failures++; $display("FAIL %s[%0d] op=%b result got=%h exp=%h", name, i, ops[i], r, e.res); end
      checks++; if (z !== (e.res == 0)) begin failures++; $display("FAIL %s[%0d] zero got=%b exp=%b", name, i, z, e.res == 0); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", name, i, lat, e.lat); end
    end
  endtask

  task automatic test_single_cycle();
    logic [3:0]   ops[] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b1010};
    logic [W-1:0] xs[]  = '{32'd5, 32'd9, 32'hFFFF_FFFF, 32'd1, 32'hF0F0_1234, 32'hFF00_FF00, 32'h0000_00F0, 32'hFFFF_FFFF, 32'd0, 32'd77, 32'd3};
    logic [W-1:0] ys[]  = '{32'd7, 32'd9, 32'd1, 32'hFFFF_FFFF, 32'h0F0F_4321, 32'h0FF0_0FF0, 32'h0000_000F, 32'd1, 32'd1, 32'd5, 32'd4};
    run_table("single", ops, xs, ys);
  endtask

  task automatic test_mul();
    logic [W-1:0] xs[] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 32'($urandom)};
    logic [W-1:0] ys[] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'd12345, 32'($urandom)};
    logic [W-1:0] r; logic z; int lat, bn; bit ok; exp_t e;
    foreach (xs[i]) begin
      send(4'b1000, xs[i], ys[i], 1'b1);
      recv(r, z, lat, bn, ok);
      take();
      checks++;
      if (!ok || sb.size() == 0) begin
        failures++; $display("FAIL mul[%0d] no_result out_valid=%b", i, ok);
        continue;
      end
      e = sb.pop_front();
      checks++; if (r !== e.res) begin failures++; $display("FAIL mul[%0d] result got=%h exp=%h", i, r, e.res); end
      checks++; if (z !== (e.res == 0)) begin failures++; $display("FAIL mul[%0d] zero got=%b exp=%b", i, z, e.res == 0); end
      checks++; if (lat !== W + 1) begin failures++; $display("FAIL mul[%0d] latency got=%0d exp=%0d", i, lat, W + 1); end
      checks++; if (bn !== W) begin failures++; $display("FAIL mul[%0d] busy_cycles got=%0d exp=%0d", i, bn, W); end
    end
  endtask

  task automatic test_divide();
    logic [3:0]   ops[] = '{4'b1100, 4'b1110, 4'b1101, 4'b1111, 4'b1100, 4'b1110, 4'b1101, 4'b1100, 4'b1110, 4'b1111};
    logic [W-1:0] xs[]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0001, 32'($urandom)};
    logic [W-1:0] ys[]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'hFFFF_FFFF, 32'($urandom_range(1, 1000))};
    run_table("divide", ops, xs, ys);
  endtask

  task automatic test_div_special();
    logic [3:0]   ops[] = '{4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1100, 4'b1110};
    logic [W-1:0] xs[]  = '{32'd55, 32'd0, 32'd42, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] ys[]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_table("div_special", ops, xs, ys);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r; logic z; int lat, bn; bit ok; exp_t e;
    bit unstable = 1'b0, rdy_seen = 1'b0;
    send(4'b0010, 32'd3, 32'd4, 1'b1);
    recv(r, z, lat, bn, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++; $display("FAIL bp_first no_result out_valid=%b", ok);
    end else begin
      e = sb.pop_front();
      checks++; if (r !== e.res) begin failures++; $display("FAIL bp_first result got=%h exp=%h", r, e.res); end
    end
    in_valid = 1'b1; alu_control = 4'b0110; a = 32'd100; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result !== 32'd7 || out_valid !== 1'b1) unstable = 1'b1;
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
    end
    checks++; if (unstable) begin failures++; $display("FAIL bp_hold result=%h out_valid=%b exp result=7 out_valid=1", result, out_valid); end
    checks++; if (rdy_seen) begin failures++; $display("FAIL bp_in_ready got=1 exp=0 during stall"); end
    in_valid = 1'b0;
    take();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_ignored_op out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r; logic z; int lat, bn; bit ok; exp_t e;
    bit spurious = 1'b0;
    send(4'b1100, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (result !== '0)      begin failures++; $display("FAIL mid_rst_result got=%h exp=0", result); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    checks++; if (spurious) begin failures++; $display("FAIL mid_rst_pulse out_valid got=1 exp=0"); end
    send(4'b0010, 32'd1, 32'd1, 1'b1);
    recv(r, z, lat, bn, ok);
    take();
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++; $display("FAIL after_rst no_result out_valid=%b", ok);
    end else begin
      e = sb.pop_front();
      checks++; if (r !== 32'd2 || r !== e.res) begin failures++; $display("FAIL after_rst result got=%h exp=%h", r, e.res); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL after_rst latency got=%0d exp=1", lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pool[12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111,
                             4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0101};
    logic [3:0]   ops[] = new[12];
    logic [W-1:0] xs[]  = new[12];
    logic [W-1:0] ys[]  = new[12];
    foreach (ops[i]) begin
      ops[i] = pool[$urandom_range(0, 11)];
      xs[i]  = $urandom;
      ys[i]  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
    end
    run_table("b2b", ops, xs, ys);
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_divide();
    test_div_special();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
